// File: rtl/g_rd_proj_secded_codec_pkg.sv
// ----------------------------------------------------------------------------
// G_RD_PROJ_functions
//   Shared types and elaboration-time helpers for the G_RD_PROJ SECDED codec.
//   - ecc_status_e : result classification of a decode beat
//   - ECC_bitsQnty : number of Hamming check bits for a payload width
//   - cw_width     : full codeword width (payload + Hamming bits + overall parity)
//   - is_pow2      : true for Hamming check-bit positions
//   - data_pos     : Hamming position of a given payload bit
// ----------------------------------------------------------------------------
package G_RD_PROJ_functions;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        CORR   = 2'd1,
        UNCORR = 2'd2
    } ecc_status_e;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int ECC_bitsQnty(int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int cw_width(int data_w);
        return data_w + ECC_bitsQnty(data_w) + 1;
    endfunction

    function automatic bit is_pow2(int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Payload bits fill the non-power-of-two positions from 3 upwards, LSB first.
    function automatic int data_pos(int idx);
        int pos;
        int n;
        pos = 0;
        n   = 0;
        for (int p = 3; p < 256; p++) begin
            if (!is_pow2(p)) begin
                if (n == idx) pos = p;
                n++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/g_rd_proj_secded_codec_hamming_core.sv
// ----------------------------------------------------------------------------
// g_rd_proj_hamming_core
//   Combinational Hamming position map, parity tree and syndrome, shared by
//   the encode and decode paths of g_rd_proj_secded_codec.
// Ports
//   payload       in   DATA_W  payload to be placed into a codeword
//   placed        out  CW_W    payload at its Hamming positions, check bits 0
//   word          in   CW_W    word whose syndrome is computed
//   syndrome      out  SYN_W   Hamming syndrome of word
//   overall       out  1       XOR of every bit of word
//   fixed_word    in   CW_W    corrected codeword
//   fixed_payload out  DATA_W  payload extracted from fixed_word
// ----------------------------------------------------------------------------
module g_rd_proj_hamming_core
    import G_RD_PROJ_functions::*;
#(
    parameter  int DATA_W = 32,
    localparam int SYN_W  = ECC_bitsQnty(DATA_W),
    localparam int CW_W   = cw_width(DATA_W)
) (
    input  logic [DATA_W-1:0] payload,
    output logic [CW_W-1:0]   placed,
    input  logic [CW_W-1:0]   word,
    output logic [SYN_W-1:0]  syndrome,
    output logic              overall,
    input  logic [CW_W-1:0]   fixed_word,
    output logic [DATA_W-1:0] fixed_payload
);

    // Bit p of the mask is set when position p is covered by check bit k.
    function automatic logic [CW_W-1:0] cover_mask(int k);
        logic [CW_W-1:0] m;
        m = '0;
        for (int p = 1; p < CW_W; p++) begin
            if (((p >> k) & 1) == 1) m = m | (CW_W'(1) << p);
        end
        return m;
    endfunction

    // Positions that carry no payload: overall parity and Hamming check bits.
    function automatic logic [CW_W-1:0] check_mask();
        logic [CW_W-1:0] m;
        m = CW_W'(1);
        for (int k = 0; k < SYN_W; k++) begin
            m = m | (CW_W'(1) << (1 << k));
        end
        return m;
    endfunction

    localparam logic [CW_W-1:0] CHECK_MASK = check_mask();

    assign placed[0] = 1'b0;

    for (genvar k = 0; k < SYN_W; k++) begin : g_check
        localparam int CPOS = 1 << k;
        localparam logic [CW_W-1:0] COVER = cover_mask(k);
        assign placed[CPOS] = 1'b0;
        assign syndrome[k]  = ^(word & COVER);
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_data
        localparam int POS = data_pos(i);
        assign placed[POS]      = payload[i];
        assign fixed_payload[i] = fixed_word[POS];
    end

    assign overall = ^word;

    // Check-bit positions of the corrected word carry no payload.
    logic check_bits_unused;
    assign check_bits_unused = ^(fixed_word & CHECK_MASK);

endmodule

// File: rtl/g_rd_proj_secded_codec.sv
// ----------------------------------------------------------------------------
// g_rd_proj_secded_codec
//   Two-stage pipelined Hamming SECDED encoder/decoder with valid/ready flow
//   control. Each beat is an encode (in_mode=0) or a decode (in_mode=1).
//   Stage 1 registers the syndrome and overall check, stage 2 the result.
//   Saturating counters track corrected and uncorrectable decode results.
// Configuration
//   G_RD_PROJ_ERR_INJECT_EN : adds inj_mask, XORed onto the output codeword of
//                             encode beats or onto in_data of decode beats.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   clr_i                  synchronous clear of both counters
//   in_valid/in_ready      input handshake
//   in_mode/in_data/in_tag beat kind, payload or codeword, sideband tag
//   inj_mask               error-injection mask (only with the macro)
//   out_valid/out_ready    output handshake
//   out_mode/out_data      beat kind, codeword or zero-extended payload
//   out_status/out_tag     NONE/CORR/UNCORR (NONE for encode), sideband tag
//   cnt_corr/cnt_uncorr    saturating error counters
// ----------------------------------------------------------------------------
module g_rd_proj_secded_codec
    import G_RD_PROJ_functions::*;
#(
    parameter  int DATA_W = 32,
    parameter  int TAG_W  = 4,
    parameter  int CNT_W  = 16,
    localparam int ECC_W  = ECC_bitsQnty(DATA_W) + 1,
    localparam int CW_W   = DATA_W + ECC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [CW_W-1:0]  in_data,
    input  logic [TAG_W-1:0] in_tag,
`ifdef G_RD_PROJ_ERR_INJECT_EN
    input  logic [CW_W-1:0]  inj_mask,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [CW_W-1:0]  out_data,
    output logic [1:0]       out_status,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_uncorr
);

    localparam int SYN_W = ECC_W - 1;

    logic              en;
    logic [CW_W-1:0]   mask;
    logic [CW_W-1:0]   placed;
    logic [CW_W-1:0]   s1_in_word;
    logic [SYN_W-1:0]  syndrome;
    logic              overall;
    logic [CW_W-1:0]   fixed_word;
    logic [DATA_W-1:0] fixed_payload;

    logic              s1_valid;
    logic              s1_mode;
    logic [TAG_W-1:0]  s1_tag;
    logic [CW_W-1:0]   s1_word;
    logic [SYN_W-1:0]  s1_syn;
    logic              s1_op;
    logic [CW_W-1:0]   s1_mask;

    logic [CW_W-1:0]   par_word;
    logic [CW_W-1:0]   enc_word;
    logic [CW_W-1:0]   flip;
    ecc_status_e       dec_status;
    ecc_status_e       out_status_q;

`ifdef G_RD_PROJ_ERR_INJECT_EN
    assign mask = inj_mask;
`else
    assign mask = '0;
`endif

    // The whole pipeline freezes while a result waits for downstream.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Encode checks the placed payload (check bits zero), so the syndrome is
    // the check-bit vector and overall is the payload parity.
    assign s1_in_word = in_mode ? (in_data ^ mask) : placed;

    g_rd_proj_hamming_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .payload       (in_data[DATA_W-1:0]),
        .placed        (placed),
        .word          (s1_in_word),
        .syndrome      (syndrome),
        .overall       (overall),
        .fixed_word    (fixed_word),
        .fixed_payload (fixed_payload)
    );

    // NOTE: every register here, including the datapath, is reset because the
    // outputs must read zero after reset, not merely be qualified by out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_tag   <= '0;
            s1_word  <= '0;
            s1_syn   <= '0;
            s1_op    <= 1'b0;
            s1_mask  <= '0;
        end else if (en) begin
            // NOTE: non-blocking so every register samples pre-edge values
            // regardless of statement order.
            s1_valid <= in_valid;
            s1_mode  <= in_mode;
            s1_tag   <= in_tag;
            s1_word  <= s1_in_word;
            s1_syn   <= syndrome;
            s1_op    <= overall;
            s1_mask  <= mask;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        par_word   = '0;
        flip       = '0;
        dec_status = NONE;

        for (int k = 0; k < SYN_W; k++) begin
            par_word = par_word | (CW_W'(s1_syn[k]) << (1 << k));
        end
        // Overall parity = payload parity ^ parity of the inserted check bits.
        enc_word = (s1_word | par_word | CW_W'(s1_op ^ (^s1_syn))) ^ s1_mask;

        if (s1_syn == '0 && !s1_op) begin
            dec_status = NONE;
        end else if (s1_op && s1_syn <= SYN_W'(CW_W - 1)) begin
            // Single error: s names the bit, s=0 is the overall-parity bit.
            dec_status = CORR;
            flip       = CW_W'(1) << s1_syn;
        end else begin
            dec_status = UNCORR;
        end
        fixed_word = s1_word ^ flip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_mode     <= 1'b0;
            out_tag      <= '0;
            out_data     <= '0;
            out_status_q <= NONE;
        end else if (en) begin
            out_valid <= s1_valid;
            out_mode  <= s1_mode;
            out_tag   <= s1_tag;
            if (s1_mode) begin
                out_data     <= CW_W'(fixed_payload);
                out_status_q <= dec_status;
            end else begin
                out_data     <= enc_word;
                out_status_q <= NONE;
            end
        end
    end

    assign out_status = out_status_q;

    // Counts follow accepted results; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (clr_i) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (out_valid && out_ready) begin
            if (out_status_q == CORR && cnt_corr != '1) begin
                cnt_corr <= cnt_corr + CNT_W'(1);
            end
            if (out_status_q == UNCORR && cnt_uncorr != '1) begin
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_g_rd_proj_secded_codec.sv
// ----------------------------------------------------------------------------
// tb_g_rd_proj_secded_codec
//   Directed bench for g_rd_proj_secded_codec at DATA_W=8 (CW_W=13), CNT_W=2.
//   Expected codewords are hand-computed for the Hamming layout with parity
//   at positions 1,2,4,8, payload at 3,5,6,7,9,10,11,12 and overall parity
//   at bit 0. Covers latency, correction/detection, stalls, saturation,
//   clear priority and asynchronous reset; injection when the macro is set.
// ----------------------------------------------------------------------------
module tb_g_rd_proj_secded_codec;

    localparam int DATA_W = 8;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = 2;
    localparam int CW_W   = 13;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             clr_i     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic             in_mode   = 1'b0;
    logic [CW_W-1:0]  in_data   = '0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_mode;
    logic [CW_W-1:0]  out_data;
    logic [1:0]       out_status;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] cnt_corr;
    logic [CNT_W-1:0] cnt_uncorr;
`ifdef G_RD_PROJ_ERR_INJECT_EN
    logic [CW_W-1:0]  inj_mask  = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    g_rd_proj_secded_codec #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .in_tag     (in_tag),
`ifdef G_RD_PROJ_ERR_INJECT_EN
        .inj_mask   (inj_mask),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mode   (out_mode),
        .out_data   (out_data),
        .out_status (out_status),
        .out_tag    (out_tag),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr)
    );

    always #5 clk = ~clk;

    // 10-beat stream: five encodes, then decodes (two of them correctable).
    logic [CW_W-1:0] v_data [10] = '{13'h00FF, 13'h0000, 13'h0001, 13'h0080, 13'h00A5,
                                     13'h144E, 13'h1131, 13'h000F, 13'h1EEE, 13'h044E};
    logic            v_mode [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [CW_W-1:0] e_data [10] = '{13'h1EEE, 13'h0000, 13'h000F, 13'h1111, 13'h144E,
                                     13'h00A5, 13'h0080, 13'h0001, 13'h00FF, 13'h00A5};
    logic [1:0]      e_stat [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                     2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
    // Single-bit errors on 0x1EEE at bits 6, 0, 12, 1, 8.
    logic [CW_W-1:0] corr_vec [5] = '{13'h1EAE, 13'h1EEF, 13'h0EEE, 13'h1EEC, 13'h1FEE};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat into an empty pipeline with out_ready=1. Returns with
    // the result on the outputs, not yet consumed.
    task automatic run_beat(input string name, input logic mode, input logic [CW_W-1:0] data,
                            input logic [TAG_W-1:0] tag, input logic [CW_W-1:0] exp_data,
                            input logic [1:0] exp_stat);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        in_tag   = tag;
        step();
        in_valid = 1'b0;
        check({name, "/lat1_valid"}, 32'(out_valid), 32'd0);
        step();
        check({name, "/valid"},  32'(out_valid),  32'd1);
        check({name, "/data"},   32'(out_data),   32'(exp_data));
        check({name, "/status"}, 32'(out_status), 32'(exp_stat));
        check({name, "/tag"},    32'(out_tag),    32'(tag));
        check({name, "/mode"},   32'(out_mode),   32'(mode));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state
        #12;
        check("rst/out_valid",  32'(out_valid),  32'd0);
        check("rst/in_ready",   32'(in_ready),   32'd1);
        check("rst/out_data",   32'(out_data),   32'd0);
        check("rst/cnt_corr",   32'(cnt_corr),   32'd0);
        check("rst/cnt_uncorr", 32'(cnt_uncorr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---------------- back-to-back encodes, latency 2, upper bits ignored
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = 13'h15FF;
        in_tag   = 4'd1;
        step();
        check("enc/lat1_valid", 32'(out_valid), 32'd0);
        in_data = 13'h0000;
        in_tag  = 4'd2;
        step();
        in_valid = 1'b0;
        check("enc_ff/valid",  32'(out_valid),  32'd1);
        check("enc_ff/data",   32'(out_data),   32'h1EEE);
        check("enc_ff/status", 32'(out_status), 32'd0);
        check("enc_ff/tag",    32'(out_tag),    32'd1);
        step();
        check("enc_00/valid",  32'(out_valid),  32'd1);
        check("enc_00/data",   32'(out_data),   32'h0000);
        check("enc_00/tag",    32'(out_tag),    32'd2);
        step();
        check("enc/idle_valid", 32'(out_valid), 32'd0);

        // ---------------- decodes
        run_beat("dec_clean", 1'b1, 13'h1EEE, 4'd3, 13'h00FF, 2'd0);
        step();
        check("dec_clean/cnt_corr", 32'(cnt_corr), 32'd0);
        run_beat("dec_b6", 1'b1, 13'h1EAE, 4'd4, 13'h00FF, 2'd1);
        step();
        check("dec_b6/cnt_corr", 32'(cnt_corr), 32'd1);
        run_beat("dec_b6b9", 1'b1, 13'h1CAE, 4'd5, 13'h00EB, 2'd2);
        step();
        check("dec_b6b9/cnt_uncorr", 32'(cnt_uncorr), 32'd1);
        check("dec_b6b9/cnt_corr",   32'(cnt_corr),   32'd1);
        // Three flips: op=1 with syndrome 14 > 12 is uncorrectable.
        run_beat("dec_3bit", 1'b1, 13'h1CAC, 4'd6, 13'h00EB, 2'd2);
        step();
        check("dec_3bit/cnt_uncorr", 32'(cnt_uncorr), 32'd2);

        // ---------------- clear, saturation, clear priority
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check("clr/cnt_corr",   32'(cnt_corr),   32'd0);
        check("clr/cnt_uncorr", 32'(cnt_uncorr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            run_beat($sformatf("corr%0d", i), 1'b1, corr_vec[i], 4'(i), 13'h00FF, 2'd1);
            step();
        end
        check("sat/cnt_corr", 32'(cnt_corr), 32'd3);
        run_beat("clr_a", 1'b1, 13'h1EAE, 4'd7, 13'h00FF, 2'd1);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check("clr_a/cnt_corr", 32'(cnt_corr), 32'd0);
        run_beat("clr_b", 1'b1, 13'h1EAE, 4'd8, 13'h00FF, 2'd1);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check("clr_b/cnt_corr", 32'(cnt_corr), 32'd0);

        // ---------------- 10-beat stream, out_ready low for cycles 3-6
        fork
            begin : driver
                logic hs;
                int   waited;
                for (int i = 0; i < 10; i++) begin
                    in_valid = 1'b1;
                    in_mode  = v_mode[i];
                    in_data  = v_data[i];
                    in_tag   = 4'(i);
                    waited   = 0;
                    hs       = 1'b0;
                    while (!hs && waited < 20) begin
                        @(negedge clk);
                        hs = in_ready;
                        step();
                        waited++;
                    end
                end
                in_valid = 1'b0;
            end
            begin : stall
                out_ready = 1'b1;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin : monitor
                int              rx;
                int              cyc;
                logic            stalled;
                logic [CW_W-1:0] sv_data;
                logic [TAG_W-1:0] sv_tag;
                logic [1:0]      sv_stat;
                rx      = 0;
                cyc     = 0;
                stalled = 1'b0;
                sv_data = '0;
                sv_tag  = '0;
                sv_stat = '0;
                while (rx < 10 && cyc < 60) begin
                    @(negedge clk);
                    cyc++;
                    if (stalled) begin
                        check("stall/valid",  32'(out_valid),  32'd1);
                        check("stall/data",   32'(out_data),   32'(sv_data));
                        check("stall/tag",    32'(out_tag),    32'(sv_tag));
                        check("stall/status", 32'(out_status), 32'(sv_stat));
                    end
                    if (out_valid && out_ready) begin
                        check($sformatf("stream%0d/tag", rx),    32'(out_tag),    32'(rx));
                        check($sformatf("stream%0d/data", rx),   32'(out_data),   32'(e_data[rx]));
                        check($sformatf("stream%0d/status", rx), 32'(out_status), 32'(e_stat[rx]));
                        rx++;
                        stalled = 1'b0;
                    end else if (out_valid) begin
                        stalled = 1'b1;
                        sv_data = out_data;
                        sv_tag  = out_tag;
                        sv_stat = out_status;
                    end else begin
                        stalled = 1'b0;
                    end
                end
                check("stream/count", 32'(rx), 32'd10);
            end
        join
        step();
        check("stream/cnt_corr", 32'(cnt_corr), 32'd2);
        step();
        check("stream/no_extra", 32'(out_valid), 32'd0);

        // ---------------- asynchronous reset with two beats in flight
        in_valid = 1'b1;
        in_mode  = 1'b1;
        in_data  = 13'h1EAE;
        in_tag   = 4'd7;
        step();
        in_data  = 13'h1EEF;
        in_tag   = 4'd8;
        step();
        in_valid = 1'b0;
        check("arst/pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst/out_valid",   32'(out_valid),  32'd0);
        check("arst/out_data",    32'(out_data),   32'd0);
        check("arst/out_tag",     32'(out_tag),    32'd0);
        check("arst/cnt_corr",    32'(cnt_corr),   32'd0);
        check("arst/cnt_uncorr",  32'(cnt_uncorr), 32'd0);
        check("arst/in_ready",    32'(in_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("arst/no_replay%0d", i), 32'(out_valid), 32'd0);
        end

`ifdef G_RD_PROJ_ERR_INJECT_EN
        // ---------------- error injection
        inj_mask = 13'h0040;
        run_beat("inj_enc", 1'b0, 13'h00FF, 4'd9, 13'h1EAE, 2'd0);
        inj_mask = '0;
        step();
        inj_mask = 13'h0040;
        run_beat("inj_dec", 1'b1, 13'h1EEE, 4'd10, 13'h00FF, 2'd1);
        inj_mask = '0;
        step();
        check("inj_dec/cnt_corr", 32'(cnt_corr), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
